// File: rtl/sparc_mem_pkg.sv
// Shared encodings for the SPARC MPU memory controller: transfer types,
// read/write strobe values and the controller FSM states.
package sparc_mem_pkg;

  localparam logic [1:0] TYPE_BYTE = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_WORD = 2'b10;

  localparam logic R_W_READ  = 1'b1;
  localparam logic R_W_WRITE = 1'b0;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

endpackage

// File: rtl/sparc_mem_ctrl_if.sv
// Request/acknowledge bus between the control unit (master) and the memory
// controller (slave). The transfer size strobe is named xfer_type because
// `type` is a reserved word in SystemVerilog.
interface sparc_mem_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              mov;
  logic              r_w;
  logic [1:0]        xfer_type;
  logic              se;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       din;
  logic [31:0]       dout;
  logic              MOC;
  logic              busy;
  logic              align_err;

  modport master (
    output mov, r_w, xfer_type, se, addr, din,
    input  dout, MOC, busy, align_err
  );

  modport slave (
    input  mov, r_w, xfer_type, se, addr, din,
    output dout, MOC, busy, align_err
  );
endinterface

// File: rtl/sparc_mem_array.sv
// 2^ADDR_W x 8 byte store exposed as four consecutive byte lanes starting at
// base; lane 0 is the byte at base. Synchronous write, combinational read.
module sparc_mem_array
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic                           Clk,
  input  logic [ADDR_W-1:0]              base,
  input  logic [NUM_LANES-1:0]           we,
  input  logic [NUM_LANES-1:0][7:0]      wd,
  output logic [NUM_LANES-1:0][7:0]      rd
);

  logic [7:0] mem [2**ADDR_W];
  logic [NUM_LANES-1:0][ADDR_W-1:0] lane_addr;

  // Lane addresses wrap naturally through the ADDR_W-bit adder.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_addr[g] = base + ADDR_W'(g);
    assign rd[g]        = mem[lane_addr[g]];
  end

  always_ff @(posedge Clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (we[i]) mem[lane_addr[i]] <= wd[i];
    end
  end

endmodule

// File: rtl/sparc_mem_ctrl.sv
// Big-endian byte/half/word memory controller with wait states and MOC
// handshake. Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses.
module sparc_mem_ctrl
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input logic            Clk,
  input logic            Clr,
  sparc_mem_ctrl_if.slave bus
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        type_q;
  logic              rw_q;
  logic              se_q;
  logic [31:0]       din_q;
  logic [31:0]       dout_q;
  logic              moc_q;
  logic              busy_q;
  logic              misalign;

  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0]      lane_mask;
  logic [NUM_LANES-1:0][7:0] lane_wd;
  logic [NUM_LANES-1:0][7:0] lane_rd;
  logic [31:0]               load_val;

`ifdef MEM_ALIGN_CHECK_EN
  logic aerr_q;
  assign misalign = ((type_q == TYPE_HALF) && addr_q[0]) ||
                    ((type_q != TYPE_BYTE) && (type_q != TYPE_HALF) && (addr_q[1:0] != 2'b00));
  assign bus.align_err = aerr_q;
`else
  assign misalign      = 1'b0;
  assign bus.align_err = 1'b0;
`endif

  // Steer right-justified store data so its MSB lands on lane 0 (addr).
  always_comb begin
    lane_mask = '0;
    lane_wd   = '0;
    case (type_q)
      TYPE_BYTE: begin
        lane_mask  = 4'b0001;
        lane_wd[0] = din_q[7:0];
      end
      TYPE_HALF: begin
        lane_mask  = 4'b0011;
        lane_wd[0] = din_q[15:8];
        lane_wd[1] = din_q[7:0];
      end
      default: begin
        lane_mask  = 4'b1111;
        lane_wd[0] = din_q[31:24];
        lane_wd[1] = din_q[23:16];
        lane_wd[2] = din_q[15:8];
        lane_wd[3] = din_q[7:0];
      end
    endcase
  end

  assign lane_we = (state == S_ACCESS && rw_q == R_W_WRITE && !misalign) ? lane_mask : '0;

  always_comb begin
    load_val = '0;
    case (type_q)
      TYPE_BYTE: load_val = {{24{se_q & lane_rd[0][7]}}, lane_rd[0]};
      TYPE_HALF: load_val = {{16{se_q & lane_rd[0][7]}}, lane_rd[0], lane_rd[1]};
      default:   load_val = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};
    endcase
  end

  sparc_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .Clk  (Clk),
    .base (addr_q),
    .we   (lane_we),
    .wd   (lane_wd),
    .rd   (lane_rd)
  );

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      type_q   <= TYPE_BYTE;
      rw_q     <= R_W_READ;
      se_q     <= 1'b0;
      din_q    <= '0;
      dout_q   <= '0;
      moc_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      aerr_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.mov) begin
            addr_q   <= bus.addr;
            type_q   <= bus.xfer_type;
            rw_q     <= bus.r_w;
            se_q     <= bus.se;
            din_q    <= bus.din;
            wait_cnt <= '0;
            busy_q   <= 1'b1;
            state    <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          if (int'(wait_cnt) >= WAIT_CYCLES - 1) begin
            wait_cnt <= '0;
            state    <= S_ACCESS;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_ACCESS: begin
          // A trapped access reports zero data whether it was a load or store.
          if (misalign)              dout_q <= '0;
          else if (rw_q == R_W_READ) dout_q <= load_val;
          moc_q <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
          aerr_q <= misalign;
`endif
          state <= S_DONE;
        end
        S_DONE: begin
          if (!bus.mov) begin
            moc_q  <= 1'b0;
            busy_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            aerr_q <= 1'b0;
`endif
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dout = dout_q;
  assign bus.MOC  = moc_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_sparc_mem_ctrl.sv
// Directed bench: a WAIT_CYCLES=3 controller for data/latency checks and a
// WAIT_CYCLES=0 controller for the zero-wait handshake.
module tb_sparc_mem_ctrl;
  import sparc_mem_pkg::*;

  logic Clk;
  logic Clr;
  int   n_cmp;
  int   n_err;
  logic [31:0] rd;
  logic        ae;

  sparc_mem_ctrl_if #(.ADDR_W(9)) b3 ();
  sparc_mem_ctrl_if #(.ADDR_W(9)) b0 ();

  sparc_mem_ctrl #(.ADDR_W(9), .WAIT_CYCLES(3)) u_dut3 (.Clk(Clk), .Clr(Clr), .bus(b3));
  sparc_mem_ctrl #(.ADDR_W(9), .WAIT_CYCLES(0)) u_dut0 (.Clk(Clk), .Clr(Clr), .bus(b0));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full operation on the 3-wait controller; entered and left in IDLE at posedge+1.
  task automatic op(input logic rw, input logic [1:0] t, input logic s,
                    input logic [8:0] a, input logic [31:0] d,
                    output logic [31:0] dat, output logic aerr);
    int n;
    b3.mov = 1'b1; b3.r_w = rw; b3.xfer_type = t; b3.se = s; b3.addr = a; b3.din = d;
    n = 0;
    do begin
      @(posedge Clk); #1; n++;
    end while (!b3.MOC && n < 40);
    chk("op_latency", 32'(n), 32'd5);
    dat  = b3.dout;
    aerr = b3.align_err;
    b3.mov = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    Clr = 1'b1;
    b3.mov = 0; b3.r_w = R_W_READ; b3.xfer_type = TYPE_BYTE; b3.se = 0; b3.addr = '0; b3.din = '0;
    b0.mov = 0; b0.r_w = R_W_READ; b0.xfer_type = TYPE_BYTE; b0.se = 0; b0.addr = '0; b0.din = '0;
    @(posedge Clk); #1;
    chk("rst_moc",  {31'b0, b3.MOC},  32'd0);
    chk("rst_busy", {31'b0, b3.busy}, 32'd0);
    chk("rst_dout", b3.dout, 32'd0);
    chk("rst_aerr", {31'b0, b3.align_err}, 32'd0);
    @(posedge Clk); #1;
    Clr = 1'b0;
    @(posedge Clk); #1;

    // Reset abort: a word write cut off in WAIT must not land.
    op(R_W_WRITE, TYPE_WORD, 0, 9'h010, 32'hCAFEF00D, rd, ae);
    op(R_W_READ,  TYPE_WORD, 0, 9'h010, 32'h0, rd, ae);
    chk("pre_abort_rd", rd, 32'hCAFEF00D);
    b3.mov = 1'b1; b3.r_w = R_W_WRITE; b3.xfer_type = TYPE_WORD; b3.addr = 9'h010; b3.din = 32'h01234567;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("mid_wait_busy", {31'b0, b3.busy}, 32'd1);
    Clr = 1'b1; #1;
    chk("abort_moc",  {31'b0, b3.MOC},  32'd0);
    chk("abort_busy", {31'b0, b3.busy}, 32'd0);
    chk("abort_dout", b3.dout, 32'd0);
    b3.mov = 1'b0;
    @(posedge Clk); #1;
    Clr = 1'b0;
    @(posedge Clk); #1;
    op(R_W_READ, TYPE_WORD, 0, 9'h010, 32'h0, rd, ae);
    chk("post_abort_rd", rd, 32'hCAFEF00D);

    // Word store, then word and byte loads.
    op(R_W_WRITE, TYPE_WORD, 0, 9'h020, 32'hDEADBEEF, rd, ae);
    op(R_W_READ,  TYPE_WORD, 0, 9'h020, 32'h0, rd, ae);
    chk("word_rd", rd, 32'hDEADBEEF);
    chk("word_aerr", {31'b0, ae}, 32'd0);
    op(R_W_READ, TYPE_BYTE, 0, 9'h020, 32'h0, rd, ae);
    chk("byte_rd_020", rd, 32'h000000DE);
    op(R_W_READ, TYPE_BYTE, 0, 9'h023, 32'h0, rd, ae);
    chk("byte_rd_023", rd, 32'h000000EF);
    op(R_W_READ, 2'b11, 0, 9'h020, 32'h0, rd, ae);
    chk("type11_rd", rd, 32'hDEADBEEF);

    // Sign/zero extension.
    op(R_W_WRITE, TYPE_BYTE, 0, 9'h030, 32'h12345680, rd, ae);
    op(R_W_READ,  TYPE_BYTE, 1, 9'h030, 32'h0, rd, ae);
    chk("byte_se1", rd, 32'hFFFFFF80);
    op(R_W_READ,  TYPE_BYTE, 0, 9'h030, 32'h0, rd, ae);
    chk("byte_se0", rd, 32'h00000080);
    op(R_W_WRITE, TYPE_HALF, 0, 9'h032, 32'hAAAA8001, rd, ae);
    chk("wr_holds_dout", rd, 32'h00000080);
    op(R_W_READ,  TYPE_HALF, 1, 9'h032, 32'h0, rd, ae);
    chk("half_se1", rd, 32'hFFFF8001);
    op(R_W_READ,  TYPE_BYTE, 0, 9'h033, 32'h0, rd, ae);
    chk("half_lo_byte", rd, 32'h00000001);
    op(R_W_READ,  TYPE_BYTE, 1, 9'h030, 32'h0, rd, ae);
    chk("byte_untouched", rd, 32'hFFFFFF80);

    // Handshake on 3-wait DUT: MOC after edge 5, held with mov, falls one edge after drop.
    b3.mov = 1'b1; b3.r_w = R_W_READ; b3.xfer_type = TYPE_WORD; b3.se = 0; b3.addr = 9'h020;
    repeat (4) begin @(posedge Clk); #1; end
    chk("w3_moc_e4", {31'b0, b3.MOC}, 32'd0);
    chk("w3_busy_e4", {31'b0, b3.busy}, 32'd1);
    @(posedge Clk); #1;
    chk("w3_moc_e5", {31'b0, b3.MOC}, 32'd1);
    chk("w3_dout_e5", b3.dout, 32'hDEADBEEF);
    @(posedge Clk); #1;
    chk("w3_moc_held", {31'b0, b3.MOC}, 32'd1);
    b3.mov = 1'b0;
    @(posedge Clk); #1;
    chk("w3_moc_fall", {31'b0, b3.MOC}, 32'd0);
    chk("w3_busy_fall", {31'b0, b3.busy}, 32'd0);

    // mov dropped in WAIT: operation completes with a single-cycle MOC.
    b3.mov = 1'b1; b3.addr = 9'h030; b3.xfer_type = TYPE_BYTE;
    @(posedge Clk); #1;
    b3.mov = 1'b0; b3.addr = 9'h023;
    repeat (4) begin @(posedge Clk); #1; end
    chk("pulse_moc_hi", {31'b0, b3.MOC}, 32'd1);
    chk("pulse_dout", b3.dout, 32'h00000080);
    @(posedge Clk); #1;
    chk("pulse_moc_lo", {31'b0, b3.MOC}, 32'd0);

    // Zero-wait DUT: MOC after edge 2.
    b0.mov = 1'b1; b0.r_w = R_W_WRITE; b0.xfer_type = TYPE_WORD; b0.addr = 9'h100; b0.din = 32'h5A5AC3C3;
    @(posedge Clk); #1;
    chk("w0_moc_e1", {31'b0, b0.MOC}, 32'd0);
    chk("w0_busy_e1", {31'b0, b0.busy}, 32'd1);
    @(posedge Clk); #1;
    chk("w0_moc_e2", {31'b0, b0.MOC}, 32'd1);
    @(posedge Clk); #1;
    chk("w0_moc_held", {31'b0, b0.MOC}, 32'd1);
    b0.mov = 1'b0;
    @(posedge Clk); #1;
    chk("w0_moc_fall", {31'b0, b0.MOC}, 32'd0);
    b0.mov = 1'b1; b0.r_w = R_W_READ; b0.xfer_type = TYPE_HALF; b0.addr = 9'h102;
    @(posedge Clk); #1;
    b0.mov = 1'b0;
    @(posedge Clk); #1;
    chk("w0_rd_moc", {31'b0, b0.MOC}, 32'd1);
    chk("w0_rd_dout", b0.dout, 32'h0000C3C3);
    @(posedge Clk); #1;
    chk("w0_rd_fall", {31'b0, b0.MOC}, 32'd0);

`ifndef MEM_ALIGN_CHECK_EN
    // Wrap-around word write across the top of the 512-byte array.
    op(R_W_WRITE, TYPE_WORD, 0, 9'h1FE, 32'h11223344, rd, ae);
    op(R_W_READ, TYPE_BYTE, 0, 9'h1FE, 32'h0, rd, ae);
    chk("wrap_1fe", rd, 32'h00000011);
    op(R_W_READ, TYPE_BYTE, 0, 9'h1FF, 32'h0, rd, ae);
    chk("wrap_1ff", rd, 32'h00000022);
    op(R_W_READ, TYPE_BYTE, 0, 9'h000, 32'h0, rd, ae);
    chk("wrap_000", rd, 32'h00000033);
    op(R_W_READ, TYPE_BYTE, 0, 9'h001, 32'h0, rd, ae);
    chk("wrap_001", rd, 32'h00000044);
    op(R_W_READ, TYPE_HALF, 0, 9'h021, 32'h0, rd, ae);
    chk("misalign_half", rd, 32'h0000ADBE);
    chk("misalign_aerr", {31'b0, ae}, 32'd0);
`else
    op(R_W_WRITE, TYPE_WORD, 0, 9'h040, 32'hA5A5A5A5, rd, ae);
    op(R_W_WRITE, TYPE_WORD, 0, 9'h041, 32'hFFFFFFFF, rd, ae);
    chk("align_err_set", {31'b0, ae}, 32'd1);
    chk("align_dout0", rd, 32'd0);
    chk("align_clear", {31'b0, b3.align_err}, 32'd0);
    op(R_W_READ, TYPE_WORD, 0, 9'h040, 32'h0, rd, ae);
    chk("align_mem_kept", rd, 32'hA5A5A5A5);
    op(R_W_READ, TYPE_HALF, 0, 9'h042, 32'h0, rd, ae);
    chk("align_half_ok", {31'b0, ae}, 32'd0);
    chk("align_half_rd", rd, 32'h0000A5A5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sparc_mem_ctrl.md
# sparc_mem_ctrl

Parametrised byte-addressed memory with a registered request/acknowledge handshake for the SPARC MPU. It replaces the fixed-latency memory stub behind the datapath's MAR/MDR. It accepts the control unit's `mov`, `r_w` and `type` strobes and returns `MOC` after a configurable number of wait states. It supports big-endian byte, halfword and word transfers, with optional sign extension on loads.

## Interface
- `ADDR_W`, 9: byte-address width; array holds 2^ADDR_W bytes.
- `WAIT_CYCLES`, 2: wait states inserted before the access; 0 allowed.
- `Clk` in 1: single clock, rising edge.
- `Clr` in 1: reset, asynchronous, active-high.
- `mov` in 1: memory operation valid (request).
- `r_w` in 1: 1 = read (load), 0 = write (store).
- `type` in 2: 00 byte, 01 halfword, 10 word, 11 treated as word.
- `se` in 1: sign-extend byte/halfword loads when 1, zero-extend when 0.
- `addr` in ADDR_W: byte address from MAR.
- `din` in 32: store data from MDR, right-justified.
- `dout` out 32: load data, right-justified, registered.
- `MOC` out 1: memory operation complete, registered.
- `busy` out 1: high in every state except IDLE.
- `align_err` out 1: misaligned access flag, valid with `MOC`.

## Operation
- FSM states:
  - IDLE: on `mov`=1, capture `addr`, `type`, `r_w`, `se` and `din`. Go to WAIT, or to ACCESS when WAIT_CYCLES=0.
  - WAIT: count WAIT_CYCLES edges, then go to ACCESS.
  - ACCESS: perform the read or write on the captured values, register `dout`, go to DONE.
  - DONE: `MOC`=1. Stay while `mov`=1; on `mov`=0 return to IDLE.
- Request inputs are sampled only in IDLE. Changes to them during an operation are ignored.
- Big-endian layout: `addr` holds the most significant byte. Bytes live at addr, addr+1, addr+2, addr+3, computed modulo 2^ADDR_W (wrap-around).
- Store behaviour:
  - byte writes `din[7:0]`;
  - halfword writes `din[15:0]`;
  - word writes `din[31:0]`;
  - other bytes are untouched.
- Load behaviour: byte and halfword loads are extended to 32 bits according to `se`; word loads return all 32 bits.
- On a write, `dout` holds its previous value.
- If `mov` drops before DONE, the operation still completes. DONE then lasts exactly one cycle (a one-cycle `MOC` pulse) before returning to IDLE.
- Memory contents are not cleared by `Clr`.

## Timing
- Reset values: state IDLE, `MOC`=0, `busy`=0, `dout`=0, `align_err`=0, wait counter 0.
- `Clr` mid-operation aborts immediately. A write whose ACCESS edge has not occurred is not performed.
- Latency: counting the edge that samples `mov` in IDLE as edge 1, `MOC` rises after edge WAIT_CYCLES+2.
  - WAIT_CYCLES=0: `MOC` after edge 2.
  - WAIT_CYCLES=2: `MOC` after edge 4.
- `dout` is valid in the same cycle `MOC` rises and is held until the next read's ACCESS edge.
- `MOC` falls on the edge after `mov` is sampled low in DONE.
- A new request is accepted no earlier than the following edge (IDLE sampling); back-to-back throughput is WAIT_CYCLES+3 cycles per operation.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Halfword requires `addr[0]`=0; word requires `addr[1:0]`=0.
  - A misaligned access performs no write and forces `dout`=0.
  - `align_err`=1 in DONE, with normal `MOC` timing; `align_err` clears on return to IDLE.
- `MEM_ALIGN_CHECK_EN` undefined:
  - Misaligned accesses proceed byte-wise with address wrap.
  - `align_err` is tied to 0.

## Structure
- Package `sparc_mem_pkg` holds:
  - transfer-type encodings (`TYPE_BYTE`, `TYPE_HALF`, `TYPE_WORD`);
  - the FSM state enum;
  - `R_W_READ`/`R_W_WRITE` constants.
- Sub-module `sparc_mem_array`: 2^ADDR_W x 8 storage with four byte lanes. It takes a base address, per-lane write enables, a synchronous write and a combinational read, and computes lane addresses modulo 2^ADDR_W.
- `sparc_mem_ctrl` contains the FSM, wait counter, request capture registers, lane steering and extension logic.

## Test plan
- Reset: assert `Clr` mid-WAIT of a word write to 0x010 → `MOC`=0, `busy`=0, `dout`=0; a later read of 0x010 returns its pre-write contents.
- Word store then load: write 0xDEADBEEF at 0x020, read word 0x020 → `dout`=0xDEADBEEF; byte 0x020 (`se`=0) → 0x000000DE; byte 0x023 → 0x000000EF.
- Sign extension: store byte 0x80 at 0x030. Byte load with `se`=1 → 0xFFFFFF80; with `se`=0 → 0x00000080. Halfword 0x8001 at 0x032 with `se`=1 → 0xFFFF8001.
- Latency/handshake with WAIT_CYCLES=0 and 3:
  - `MOC` rises after edge 2 and edge 5 respectively;
  - `MOC` held while `mov`=1 and falls one edge after `mov`=0;
  - dropping `mov` in WAIT gives a one-cycle `MOC` pulse.
- Wrap-around (ADDR_W=9, check off): word write 0x11223344 at 0x1FE → bytes 0x1FE=0x11, 0x1FF=0x22, 0x000=0x33, 0x001=0x44.
- With `MEM_ALIGN_CHECK_EN`: word write at 0x041 → `align_err`=1 with `MOC`, memory unchanged, `dout`=0; halfword read at 0x042 → `align_err`=0.
